csa_accumulate_controller: RTL and testbench
============================================

// Module: csa_accumulate_controller
// PURPOSE
//  Sequences a multi-operand sum through one carry_save_adder (CSA) stage.
//  Accepts a burst of N operands over a valid/ready stream and folds each one into registered sum/carry vectors.
//  When the burst ends, performs one carry-propagate add (CPA) and presents the result on a valid/ready output.
//  Front-end for dot-product and multiplier partial-product paths in the fast-arithmetic datapath.
// PARAMETERS
//  WIDTH      8                          operand width
//  MAX_OPS    16                         max operands per burst
//  CNT_W      $clog2(MAX_OPS+1)          width of iCount and of the remaining-operand counter
//  ACC_WIDTH  WIDTH+$clog2(MAX_OPS)      sum/carry/result width; cannot overflow for N<=MAX_OPS
// PORTS
//  iClk      in   1          clock, rising edge
//  iRst      in   1          synchronous, active-high reset
//  iStart    in   1          begin burst; sampled only in IDLE
//  iCount    in   CNT_W      operands in burst; sampled with iStart
//  iValid    in   1          operand valid
//  iData     in   WIDTH      operand, unsigned
//  oReady    out  1          operand accepted when iValid&oReady
//  oValid    out  1          result valid
//  oResult   out  ACC_WIDTH  sum of the burst operands
//  iReady    in   1          result consumed when oValid&iReady
//  oBusy     out  1          high in any state other than IDLE
// BEHAVIOUR
//  Reset values: state=IDLE; all outputs 0; sum/carry/counter registers 0.
//  FSM states: IDLE -> ACCUM -> RESOLVE -> DONE -> IDLE.
//  IDLE:
//   - On iStart: clear sum S and carry C.
//   - Load cnt=min(iCount,MAX_OPS).
//   - Next state ACCUM if cnt!=0, else RESOLVE.
//  ACCUM:
//   - oReady=1.
//   - Each handshake: {S,C} <= CSA(S, C, zero-extended iData); carry out of bit ACC_WIDTH-1 discarded; cnt--.
//   - Handshake with cnt==1 -> RESOLVE. No handshake -> hold S, C, cnt.
//  RESOLVE:
//   - oResult <= S+C (mod 2^ACC_WIDTH); 1 cycle -> DONE.
//  DONE:
//   - oValid=1; oResult stable until handshake.
//   - On iReady -> IDLE. A new iStart is accepted in the following cycle, not in the handshake cycle.
//  Latency:
//   - iStart -> first oReady: 1 cycle.
//   - Last operand handshake -> oValid: 2 cycles.
//  Burst handling:
//   - iStart outside IDLE is ignored.
//   - iValid outside ACCUM is ignored (oReady=0).
//   - iCount>MAX_OPS clamps to MAX_OPS.
//   - iCount=0 yields oResult=0.
//  Reset mid-burst: next cycle IDLE, outputs 0; the partial sum is discarded.
// CONFIGURATION
//  CPA_PIPELINE_EN defined:
//   - RESOLVE takes 2 cycles: cycle 1 registers the low-half sum and its carry, cycle 2 the high half.
//   - Last operand -> oValid becomes 3 cycles.
//  CPA_PIPELINE_EN undefined:
//   - Single-cycle CPA as above.
//  Ports and results are identical in both builds.
// STRUCTURE
//  Package fast_arith_pkg: state encodings (IDLE/ACCUM/RESOLVE/DONE) and the clog2 helper.
//  One sub-module instance: carry_save_adder #(.WIDTH(ACC_WIDTH)). Its oC[ACC_WIDTH-1:0] feeds the C register.
//  FSM, counter and CPA stay in this module.
// TESTING (WIDTH=8, MAX_OPS=16, ACC_WIDTH=12; run every test in both CPA_PIPELINE_EN builds)
//  1. Basic sum: iCount=3; data 3,5,7 back-to-back -> oResult=15; oValid 2 cycles (3 pipelined) after last handshake.
//  2. Full-scale: iCount=16, all data 255 -> oResult=0xFF0 (4080); no wrap.
//  3. Flow control:
//     - iCount=4 (10,20,30,40) with iValid gaps.
//     - Hold iReady=0 for 5 cycles -> oValid and oResult=100 held stable.
//     - oBusy falls 1 cycle after handshake.
//  4. Edge counts:
//     - iCount=0 -> oResult=0, no oReady pulse.
//     - iCount=20 -> exactly 16 operands accepted.
//  5. Start/reset interference:
//     - Pulse iStart mid-ACCUM -> ignored; the sum matches the first burst.
//     - Assert iRst mid-ACCUM -> next cycle IDLE, oBusy=0.
//     - New burst (1,2) -> 3.

Source files
------------

// File: rtl/csa_accumulate_controller_pkg.sv
// Shared constants for the fast-arithmetic datapath: controller state encodings and a clog2 helper.
package fast_arith_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCUM   = 2'd1;
    localparam logic [1:0] ST_RESOLVE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/csa_accumulate_controller_if.sv
// Operand stream, burst control and result stream of the CSA accumulate controller.
interface csa_accumulate_controller_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_W     = 5,
    parameter int unsigned ACC_WIDTH = 12
);
    logic                 iStart;
    logic [CNT_W-1:0]     iCount;
    logic                 iValid;
    logic [WIDTH-1:0]     iData;
    logic                 oReady;
    logic                 oValid;
    logic [ACC_WIDTH-1:0] oResult;
    logic                 iReady;
    logic                 oBusy;

    modport master (
        output iStart, iCount, iValid, iData, iReady,
        input  oReady, oValid, oResult, oBusy
    );

    modport slave (
        input  iStart, iCount, iValid, iData, iReady,
        output oReady, oValid, oResult, oBusy
    );
endinterface

// File: rtl/csa_accumulate_controller_csa.sv
// One 3:2 carry-save stage; the carry vector is pre-shifted and its top carry dropped.
module carry_save_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic [WIDTH-1:0] iCin,
    output logic [WIDTH-1:0] oS,
    output logic [WIDTH-1:0] oC
);
    logic [WIDTH-2:0] maj;

    assign oS  = iA ^ iB ^ iCin;
    assign maj = (iA[WIDTH-2:0] & iB[WIDTH-2:0])
               | (iA[WIDTH-2:0] & iCin[WIDTH-2:0])
               | (iB[WIDTH-2:0] & iCin[WIDTH-2:0]);
    assign oC  = {maj, 1'b0};
endmodule

// File: rtl/csa_accumulate_controller.sv
// Folds a burst of operands into carry-save sum/carry registers, then resolves them with one CPA.
// Define CPA_PIPELINE_EN to split the CPA over two cycles (low half, then high half).
module csa_accumulate_controller
    import fast_arith_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_OPS   = 16,
    parameter int unsigned CNT_W     = clog2(MAX_OPS + 1),
    parameter int unsigned ACC_WIDTH = WIDTH + clog2(MAX_OPS)
) (
    input logic                       iClk,
    input logic                       iRst,
    csa_accumulate_controller_if.slave bus
);
`ifdef CPA_PIPELINE_EN
    localparam int unsigned HALF = ACC_WIDTH / 2;
    localparam int unsigned HI_W = ACC_WIDTH - HALF;
    logic [HALF:0] lo_q, lo_d;
    logic          phase_q, phase_d;
`endif

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_load;
    logic [ACC_WIDTH-1:0] sum_q, sum_d, carry_q, carry_d;
    logic [ACC_WIDTH-1:0] result_q, result_d, csa_s, csa_c;
    logic                 ready_q, ready_d, valid_q, valid_d, busy_q, busy_d;

    carry_save_adder #(.WIDTH(ACC_WIDTH)) u_csa (
        .iA   (sum_q),
        .iB   (carry_q),
        .iCin (ACC_WIDTH'(bus.iData)),
        .oS   (csa_s),
        .oC   (csa_c)
    );

    assign cnt_load = (bus.iCount > CNT_W'(MAX_OPS)) ? CNT_W'(MAX_OPS) : bus.iCount;

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        result_d = result_q;
        ready_d  = ready_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
`ifdef CPA_PIPELINE_EN
        lo_d     = lo_q;
        phase_d  = phase_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.iStart) begin
                    sum_d   = '0;
                    carry_d = '0;
                    cnt_d   = cnt_load;
                    busy_d  = 1'b1;
                    if (cnt_load != '0) begin
                        state_d = ST_ACCUM;
                        ready_d = 1'b1;
                    end else begin
                        state_d = ST_RESOLVE;
                    end
                end
            end
            ST_ACCUM: begin
                if (bus.iValid && ready_q) begin
                    sum_d   = csa_s;
                    carry_d = csa_c;
                    cnt_d   = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_RESOLVE;
                        ready_d = 1'b0;
                    end
                end
            end
            ST_RESOLVE: begin
`ifdef CPA_PIPELINE_EN
                if (!phase_q) begin
                    lo_d    = {1'b0, sum_q[HALF-1:0]} + {1'b0, carry_q[HALF-1:0]};
                    phase_d = 1'b1;
                end else begin
                    result_d = {sum_q[ACC_WIDTH-1:HALF] + carry_q[ACC_WIDTH-1:HALF] + HI_W'(lo_q[HALF]),
                                lo_q[HALF-1:0]};
                    phase_d  = 1'b0;
                    state_d  = ST_DONE;
                    valid_d  = 1'b1;
                end
`else
                result_d = sum_q + carry_q;
                state_d  = ST_DONE;
                valid_d  = 1'b1;
`endif
            end
            ST_DONE: begin
                if (bus.iReady) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sum_q    <= '0;
            carry_q  <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef CPA_PIPELINE_EN
            lo_q     <= '0;
            phase_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
`ifdef CPA_PIPELINE_EN
            lo_q     <= lo_d;
            phase_q  <= phase_d;
`endif
        end
    end

    assign bus.oReady  = ready_q;
    assign bus.oValid  = valid_q;
    assign bus.oResult = result_q;
    assign bus.oBusy   = busy_q;
endmodule

// File: tb/tb_csa_accumulate_controller.sv
// Directed bench for csa_accumulate_controller (WIDTH=8, MAX_OPS=16, ACC_WIDTH=12); honours CPA_PIPELINE_EN.
module tb_csa_accumulate_controller;
`ifdef CPA_PIPELINE_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   accepted;

    csa_accumulate_controller_if #(.WIDTH(8), .CNT_W(5), .ACC_WIDTH(12)) bus ();

    csa_accumulate_controller #(.WIDTH(8), .MAX_OPS(16)) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Offer one operand and hold it until the cycle in which it is accepted
    task automatic send(input logic [7:0] d);
        int n;
        bus.iValid = 1'b1;
        bus.iData  = d;
        n = 0;
        while (bus.oReady !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) chk("send_timeout", 32'(n), 32'd0);
        step();
        bus.iValid = 1'b0;
    endtask

    task automatic start(input logic [4:0] cnt);
        bus.iStart = 1'b1;
        bus.iCount = cnt;
        step();
        bus.iStart = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (bus.oValid !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        if (n >= 30) chk({tag, "_timeout"}, 32'(n), 32'd0);
    endtask

    task automatic consume(input string tag);
        bus.iReady = 1'b1;
        step();
        bus.iReady = 1'b0;
        chk({tag, "_valid_after"}, 32'(bus.oValid), 32'd0);
        chk({tag, "_busy_after"}, 32'(bus.oBusy), 32'd0);
    endtask

    initial begin
        bus.iStart = 1'b0;
        bus.iCount = '0;
        bus.iValid = 1'b0;
        bus.iData  = '0;
        bus.iReady = 1'b0;
        step();
        step();
        chk("rst_ready", 32'(bus.oReady), 32'd0);
        chk("rst_valid", 32'(bus.oValid), 32'd0);
        chk("rst_result", 32'(bus.oResult), 32'd0);
        chk("rst_busy", 32'(bus.oBusy), 32'd0);
        rst = 1'b0;
        step();

        // 1: basic sum with latency check
        start(5'd3);
        chk("t1_ready_lat", 32'(bus.oReady), 32'd1);
        chk("t1_busy", 32'(bus.oBusy), 32'd1);
        send(8'd3);
        send(8'd5);
        send(8'd7);
        for (int i = 0; i < 1 + EXTRA; i++) begin
            chk("t1_valid_early", 32'(bus.oValid), 32'd0);
            step();
        end
        chk("t1_valid_lat", 32'(bus.oValid), 32'd1);
        chk("t1_result", 32'(bus.oResult), 32'd15);
        consume("t1");

        // 2: full-scale, no wrap
        start(5'd16);
        for (int i = 0; i < 16; i++) send(8'd255);
        wait_valid("t2");
        chk("t2_result", 32'(bus.oResult), 32'd4080);
        consume("t2");

        // 3: operand gaps and result back-pressure
        start(5'd4);
        step();
        send(8'd10);
        step();
        step();
        send(8'd20);
        send(8'd30);
        step();
        send(8'd40);
        wait_valid("t3");
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", 32'(bus.oValid), 32'd1);
            chk("t3_hold_result", 32'(bus.oResult), 32'd100);
            step();
        end
        chk("t3_busy_before", 32'(bus.oBusy), 32'd1);
        consume("t3");

        // 4a: zero count
        start(5'd0);
        chk("t4a_busy", 32'(bus.oBusy), 32'd1);
        for (int i = 0; i < 1 + EXTRA; i++) begin
            chk("t4a_no_ready", 32'(bus.oReady), 32'd0);
            step();
        end
        chk("t4a_valid", 32'(bus.oValid), 32'd1);
        chk("t4a_result", 32'(bus.oResult), 32'd0);
        consume("t4a");

        // 4b: count above MAX_OPS clamps to 16 operands
        start(5'd20);
        bus.iValid = 1'b1;
        bus.iData  = 8'd1;
        accepted   = 0;
        for (int i = 0; i < 24; i++) begin
            if (bus.oReady === 1'b1) accepted++;
            step();
        end
        bus.iValid = 1'b0;
        chk("t4b_accepted", 32'(accepted), 32'd16);
        wait_valid("t4b");
        chk("t4b_result", 32'(bus.oResult), 32'd16);
        consume("t4b");

        // 5a: iStart during ACCUM is ignored
        start(5'd3);
        send(8'd4);
        bus.iStart = 1'b1;
        bus.iCount = 5'd2;
        step();
        bus.iStart = 1'b0;
        send(8'd5);
        send(8'd6);
        wait_valid("t5a");
        chk("t5a_result", 32'(bus.oResult), 32'd15);
        consume("t5a");

        // 5b: reset mid-burst, then a fresh burst
        start(5'd5);
        send(8'd9);
        send(8'd9);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5b_busy", 32'(bus.oBusy), 32'd0);
        chk("t5b_ready", 32'(bus.oReady), 32'd0);
        chk("t5b_result", 32'(bus.oResult), 32'd0);
        step();
        start(5'd2);
        send(8'd1);
        send(8'd2);
        wait_valid("t5c");
        chk("t5c_result", 32'(bus.oResult), 32'd3);
        consume("t5c");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
